// File: rtl/fifth_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fifth_mem_arbiter
//
// Shares the single synchronous data-RAM port (1-cycle read latency) between
// two masters: port 0 (fifth CPU data port) and port 1 (loader / DMA).
// Round-robin arbitration with a bounded hold: a port that keeps winning while
// the other one waits is cut off after MAX_HOLD consecutive grants.
//
// Optional feature (macro FIFTH_ARB_LOCK_EN): adds input p1_lock. While port 1
// owns the RAM and p1_lock is high, port 0 is never granted and the hold limit
// is ignored; ownership stays with port 1 even in cycles without a p1 request.
//
// Ports:
//   clk, reset (async, active-low)
//   pN_req/pN_we/pN_addr/pN_wdata : request side of port N (held until gnt)
//   pN_gnt                        : access issued to the RAM this cycle
//   pN_rvalid/pN_rdata            : read return, one cycle after a read grant
//   ram_addr/ram_we/ram_wdata     : RAM command (zero when nothing is granted)
//   ram_rdata                     : RAM read data, valid the cycle after addr
//   p1_lock                       : only with FIFTH_ARB_LOCK_EN
// -----------------------------------------------------------------------------
module fifth_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FIFTH_ARB_LOCK_EN
    input  logic              p1_lock,
`endif
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [7:0]        hold_inc;
    logic              rd_pend0_q, rd_pend1_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
    logic              gnt0, gnt1;
    logic              lock_act;

    assign hold_inc = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = IDLE;
        last_d     = last_q;
        hold_cnt_d = 8'd0;
        lock_act   = 1'b0;
`ifdef FIFTH_ARB_LOCK_EN
        lock_act   = (state_q == OWN1) && p1_lock;
`endif
        if (lock_act) begin
            gnt1 = p1_req;
        end else if (p0_req && p1_req) begin
            unique case (state_q)
                OWN0:    if (hold_cnt_q < MAX_HOLD_C) gnt0 = 1'b1; else gnt1 = 1'b1;
                OWN1:    if (hold_cnt_q < MAX_HOLD_C) gnt1 = 1'b1; else gnt0 = 1'b1;
                default: if (last_q) gnt0 = 1'b1; else gnt1 = 1'b1;
            endcase
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end

        // No grant may escape while reset is held low.
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        // hold_cnt counts consecutive grants to the owner while the other
        // port waits; a fresh owner starts the count at 1.
        if (gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            if (p1_req) hold_cnt_d = (state_q == OWN0) ? hold_inc : 8'd1;
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            if (p0_req) hold_cnt_d = (state_q == OWN1) ? hold_inc : 8'd1;
        end

        // Locked: port 1 keeps ownership even without a request. The count is
        // pinned at saturation while port 0 waits so that port 0 wins as soon
        // as the lock drops.
        if (lock_act) begin
            state_d    = OWN1;
            hold_cnt_d = p0_req ? 8'hFF : 8'd0;
        end
    end

    always_comb begin
        ram_we    = (gnt0 & p0_we) | (gnt1 & p1_we);
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
        end else if (gnt1) begin
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= 8'd0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend0_q <= gnt0 & ~p0_we;
            rd_pend1_q <= gnt1 & ~p1_we;
            if (rd_pend0_q) p0_rdata_q <= ram_rdata;
            if (rd_pend1_q) p1_rdata_q <= ram_rdata;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = rd_pend0_q;
    assign p1_rvalid = rd_pend1_q;
    // Read data passes straight through in the return cycle and is held
    // afterwards from the capture register.
    assign p0_rdata  = rd_pend0_q ? ram_rdata : p0_rdata_q;
    assign p1_rdata  = rd_pend1_q ? ram_rdata : p1_rdata_q;

endmodule

// File: tb/tb_fifth_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fifth_mem_arbiter: directed phases plus randomized traffic.
// The stimulus process runs a reference arbiter/memory model and pushes the
// expected per-cycle outputs and read data into queues; a monitor on the
// falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_fifth_mem_arbiter;

    localparam int HOLD = 3;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
`ifdef FIFTH_ARB_LOCK_EN
    logic        p1_lock;
    initial p1_lock = 1'b0;
`endif

    fifth_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset),
`ifdef FIFTH_ARB_LOCK_EN
        .p1_lock(p1_lock),
`endif
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM seen by the DUT.
    logic [15:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr[9:0]] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr[9:0]];
    end

    typedef struct {
        logic        g0, g1, we;
        logic [15:0] addr, wdata;
        logic        rv0, rv1;
        logic [15:0] held0, held1;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] rdq0[$];
    logic [15:0] rdq1[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [15:0] model_mem [0:1023];
    int          owner;      // -1 none, else port that owned previous cycle
    int          last;       // most recently granted port
    int          streak;     // consecutive grants to owner while other waits
    bit          rv_exp  [2];
    logic [15:0] rv_data [2];
    logic [15:0] held    [2];
    // requester state
    bit          pend [2];
    bit          pwe  [2];
    logic [15:0] paddr[2];
    logic [15:0] pwd  [2];

    task automatic new_req(input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
        pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
    endtask

    task automatic rand_req(input int p);
        new_req(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
    endtask

    // One clock cycle: drive requests, predict outputs, push expectations.
    task automatic do_cycle(input bit rst_now);
        exp_t e;
        int   w;
        bit   other;
        @(posedge clk);
        #1;
        reset = ~rst_now;
        if (rst_now) begin
            pend[0] = 1'b0; pend[1] = 1'b0;
        end
        p0_req = pend[0]; p0_we = pwe[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
        p1_req = pend[1]; p1_we = pwe[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
        e.g0 = 1'b0; e.g1 = 1'b0; e.we = 1'b0; e.addr = 16'h0; e.wdata = 16'h0;
        if (rst_now) begin
            owner = -1; last = 1; streak = 0;
            rv_exp[0] = 1'b0; rv_exp[1] = 1'b0;
            held[0] = 16'h0; held[1] = 16'h0;
            rdq0.delete(); rdq1.delete();
            e.rv0 = 1'b0; e.rv1 = 1'b0; e.held0 = 16'h0; e.held1 = 16'h0;
        end else begin
            e.rv0 = rv_exp[0]; e.rv1 = rv_exp[1];
            e.held0 = held[0]; e.held1 = held[1];
            if (rv_exp[0]) held[0] = rv_data[0];
            if (rv_exp[1]) held[1] = rv_data[1];
            rv_exp[0] = 1'b0; rv_exp[1] = 1'b0;
            w = -1;
            if (pend[0] && pend[1]) begin
                if (owner < 0)          w = 1 - last;
                else if (streak < HOLD) w = owner;
                else                    w = 1 - owner;
            end else if (pend[0]) w = 0;
            else if (pend[1])     w = 1;
            if (w >= 0) begin
                e.g0 = (w == 0); e.g1 = (w == 1);
                e.we = pwe[w]; e.addr = paddr[w]; e.wdata = pwd[w];
                if (pwe[w]) model_mem[paddr[w][9:0]] = pwd[w];
                else begin
                    rv_exp[w]  = 1'b1;
                    rv_data[w] = model_mem[paddr[w][9:0]];
                    if (w == 0) rdq0.push_back(rv_data[w]);
                    else        rdq1.push_back(rv_data[w]);
                end
                other = (w == 0) ? pend[1] : pend[0];
                if (!other)          streak = 0;
                else if (w == owner) streak = (streak < 255) ? streak + 1 : 255;
                else                 streak = 1;
                owner = w; last = w; pend[w] = 1'b0;
            end else begin
                owner = -1; streak = 0;
            end
        end
        expq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] d;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("p0_gnt",    p0_gnt,    e.g0);
            chk("p1_gnt",    p1_gnt,    e.g1);
            chk("ram_we",    ram_we,    e.we);
            chk("ram_addr",  ram_addr,  e.addr);
            chk("ram_wdata", ram_wdata, e.wdata);
            chk("p0_rvalid", p0_rvalid, e.rv0);
            chk("p1_rvalid", p1_rvalid, e.rv1);
            if (p0_rvalid) begin
                if (rdq0.size() > 0) begin
                    d = rdq0.pop_front();
                    chk("p0_rdata", p0_rdata, d);
                end else begin
                    miscompares++;
                    $display("FAIL p0_rdata: rvalid with data %0h, no read outstanding", p0_rdata);
                end
            end else chk("p0_rdata_hold", p0_rdata, e.held0);
            if (p1_rvalid) begin
                if (rdq1.size() > 0) begin
                    d = rdq1.pop_front();
                    chk("p1_rdata", p1_rdata, d);
                end else begin
                    miscompares++;
                    $display("FAIL p1_rdata: rvalid with data %0h, no read outstanding", p1_rdata);
                end
            end else chk("p1_rdata_hold", p1_rdata, e.held1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i]   = 16'h0;
            model_mem[i] = 16'h0;
        end
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 16'h0; pwd[p] = 16'h0;
            rv_exp[p] = 1'b0; rv_data[p] = 16'h0; held[p] = 16'h0;
        end
        owner = -1; last = 1; streak = 0;
        reset = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

        repeat (3) do_cycle(1'b1);
        do_cycle(1'b0);

        // First tie after reset, then continuous requests from both ports.
        for (int c = 0; c < 10; c++) begin
            if (!pend[0]) rand_req(0);
            if (!pend[1]) rand_req(1);
            do_cycle(1'b0);
        end
        repeat (2) do_cycle(1'b0);

        // Single-port write then read-back.
        new_req(0, 1'b1, 16'h0012, 16'hBEEF);
        do_cycle(1'b0);
        new_req(0, 1'b0, 16'h0012, 16'h0000);
        do_cycle(1'b0);
        repeat (2) do_cycle(1'b0);

        // Hold limit: port 1 owns alone, then both request continuously.
        new_req(1, 1'b1, 16'h0005, 16'h1234);
        do_cycle(1'b0);
        for (int c = 0; c < 12; c++) begin
            if (!pend[0]) rand_req(0);
            if (!pend[1]) rand_req(1);
            do_cycle(1'b0);
        end
        repeat (2) do_cycle(1'b0);

        // Back-to-back reads on port 1.
        for (int k = 0; k < 3; k++) begin
            new_req(1, 1'b1, 16'(16'h0100 + k), 16'(16'hA500 + k));
            do_cycle(1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            new_req(1, 1'b0, 16'(16'h0100 + k), 16'h0);
            do_cycle(1'b0);
        end
        repeat (2) do_cycle(1'b0);

        // Randomized traffic, including requests dropped before grant.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 60) rand_req(p);
                else if (pend[p] && $urandom_range(0, 99) < 4) pend[p] = 1'b0;
            end
            do_cycle(1'b0);
        end
        repeat (2) do_cycle(1'b0);

        // Reset while a port-0 read is outstanding, then the tie again.
        new_req(0, 1'b0, 16'h0012, 16'h0);
        do_cycle(1'b0);
        repeat (2) do_cycle(1'b1);
        do_cycle(1'b0);
        for (int c = 0; c < 8; c++) begin
            if (!pend[0]) rand_req(0);
            if (!pend[1]) rand_req(1);
            do_cycle(1'b0);
        end

        repeat (3) do_cycle(1'b0);
        for (int t = 0; t < 5 && expq.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        chk("expq_drained", expq.size(), 0);
        chk("rdq0_drained", rdq0.size(), 0);
        chk("rdq1_drained", rdq1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
